// File: rtl/npu_cfg_pkg.sv
// Shared definitions for the NPU configuration path: word layout,
// command encodings and loader FSM state encodings.
package npu_cfg_pkg;

   localparam int unsigned CFG_WORD_W = 26;
   localparam int unsigned CFG_ADDR_W = 8;
   localparam int unsigned CFG_DATA_W = 16;
   localparam int unsigned CFG_LEN_W  = 8;

   // Field positions inside a config word
   localparam int unsigned CMD_MSB  = 25;
   localparam int unsigned CMD_LSB  = 24;
   localparam int unsigned ADDR_MSB = 23;
   localparam int unsigned ADDR_LSB = 16;
   localparam int unsigned DATA_MSB = 15;
   localparam int unsigned DATA_LSB = 0;

   typedef enum logic [1:0] {
      CMD_WRITE = 2'b00,
      CMD_BURST = 2'b01,
      CMD_START = 2'b10,
      CMD_NOP   = 2'b11
   } cmd_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_POP   = 3'd1,
      S_CAPT  = 3'd2,
      S_WR    = 3'd3,
      S_BPOP  = 3'd4,
      S_BCAPT = 3'd5,
      S_BWR   = 3'd6,
      S_SWAIT = 3'd7
   } state_e;

endpackage

// File: rtl/npu_config_loader_if.sv
// Bus bundle between the config loader, its source FIFO and the NPU
// config port. master = loader side, slave = FIFO/NPU side.
interface npu_config_loader_if #(
   parameter int unsigned WORD_W = 26,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 16
);
   logic [WORD_W-1:0] fifo_dout;
   logic              fifo_empty;
   logic              fifo_rd_en;
   logic              cfg_wr_en;
   logic [ADDR_W-1:0] cfg_addr;
   logic [DATA_W-1:0] cfg_data;
   logic              cfg_ready;
   logic              npu_busy;
   logic              npu_start;
   logic              busy;

   modport master (
      input  fifo_dout, fifo_empty, cfg_ready, npu_busy,
      output fifo_rd_en, cfg_wr_en, cfg_addr, cfg_data, npu_start, busy
   );

   modport slave (
      output fifo_dout, fifo_empty, cfg_ready, npu_busy,
      input  fifo_rd_en, cfg_wr_en, cfg_addr, cfg_data, npu_start, busy
   );
endinterface

// File: rtl/npu_config_loader.sv
// Pops config words from a non-FWFT FIFO (1-cycle read latency),
// decodes WRITE / BURST / START / NOP and drives the NPU config
// write port and start pulse.
module npu_config_loader
   import npu_cfg_pkg::*;
#(
   parameter int unsigned WORD_W = 26,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned LEN_W  = 8
) (
   input  logic                clk,
   input  logic                srst,
   npu_config_loader_if.master bus
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [LEN_W-1:0]  count_q, count_d;

   logic              rd_en;
   logic              wr_en;
   logic              start;

   cmd_e              w_cmd;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_data;
   logic [LEN_W-1:0]  w_len;

   assign w_cmd  = cmd_e'(bus.fifo_dout[WORD_W-1 -: 2]);
   assign w_addr = bus.fifo_dout[DATA_W +: ADDR_W];
   assign w_data = bus.fifo_dout[0 +: DATA_W];
   assign w_len  = w_data[LEN_W-1:0];

   // State and datapath registers; reset drops any pending write
   always_ff @(posedge clk) begin
      if (srst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         count_q <= count_d;
      end
   end

   // Next-state, datapath update and output decode
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      count_d = count_q;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      start   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!bus.fifo_empty) state_d = S_POP;
         end
         S_POP: begin
            if (!bus.fifo_empty) begin
               rd_en   = 1'b1;
               state_d = S_CAPT;
            end
         end
         S_CAPT: begin
            case (w_cmd)
               CMD_WRITE: begin
                  addr_d  = w_addr;
                  data_d  = w_data;
                  state_d = S_WR;
               end
               CMD_BURST: begin
                  if (w_len == '0) begin
                     state_d = S_IDLE;
                  end else begin
                     addr_d  = w_addr;
                     count_d = w_len;
                     state_d = S_BPOP;
                  end
               end
               CMD_START: state_d = S_SWAIT;
               default:   state_d = S_IDLE;
            endcase
         end
         S_WR: begin
            wr_en = 1'b1;
            if (bus.cfg_ready) state_d = S_IDLE;
         end
         S_BPOP: begin
            if (!bus.fifo_empty) begin
               rd_en   = 1'b1;
               state_d = S_BCAPT;
            end
         end
         S_BCAPT: begin
            data_d  = w_data;
            state_d = S_BWR;
         end
         S_BWR: begin
            wr_en = 1'b1;
            if (bus.cfg_ready) begin
               addr_d  = addr_q + ADDR_W'(1);
               count_d = count_q - LEN_W'(1);
               state_d = (count_q == LEN_W'(1)) ? S_IDLE : S_BPOP;
            end
         end
         S_SWAIT: begin
            if (!bus.npu_busy) begin
               start   = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.cfg_wr_en  = wr_en;
   assign bus.cfg_addr   = addr_q;
   assign bus.cfg_data   = data_q;
   assign bus.npu_start  = start;
   assign bus.busy       = (state_q != S_IDLE);

endmodule
